// File: rtl/link_slave_rx.sv
// Receive side of the 4-byte burst link: answers the req/ack handshake, packs
// each burst into a 32-bit word and queues the words for a valid/ready consumer.
module link_slave_rx #(
    parameter int ACK_DELAY  = 0,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          req,
    input  logic [7:0]                    data_in,
    output logic                          ack,
    output logic                          word_valid,
    input  logic                          word_ready,
    output logic [31:0]                   word_data,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic [1:0]                    byte_idx,
    output logic                          proto_err
);

    localparam int AW          = $clog2(FIFO_DEPTH);
    localparam int DLY_LAST_I  = (ACK_DELAY > 0) ? (ACK_DELAY - 1) : 0;
    localparam logic [3:0]  DLY_LAST = DLY_LAST_I[3:0];
    localparam logic [AW:0] FULL_CNT = FIFO_DEPTH[AW:0];

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_ACK  = 2'd2
    } state_t;

    state_t         state_r;
    state_t         state_next_s;
    logic [3:0]     wait_cnt_r;
    logic [3:0]     wait_cnt_next_s;
    logic           capture_s;
    logic           abort_s;
    logic           gate_open_s;

    logic           ack_r;
    logic           proto_err_r;
    logic [1:0]     byte_idx_r;
    logic [7:0]     lane0_r;
    logic [7:0]     lane1_r;
    logic [7:0]     lane2_r;

    logic [31:0]    mem_r [FIFO_DEPTH];
    logic [AW-1:0]  wr_ptr_r;
    logic [AW-1:0]  rd_ptr_r;
    logic [AW-1:0]  rd_next_s;
    logic [AW:0]    count_r;
    logic [AW:0]    count_next_s;
    logic           word_valid_r;
    logic [31:0]    word_data_r;
    logic           push_s;
    logic           pop_s;
    logic [31:0]    push_word_s;

    // The last byte of a burst may only be accepted while there is room for its word.
    assign gate_open_s = (byte_idx_r != 2'd3) || (count_r < FULL_CNT);
    assign push_s      = capture_s && (byte_idx_r == 2'd3);
    assign pop_s       = word_valid_r && word_ready;
    assign push_word_s = {data_in, lane2_r, lane1_r, lane0_r};

    // Handshake state register and ack-delay counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= ST_IDLE;
            wait_cnt_r <= 4'd0;
        end else begin
            state_r    <= state_next_s;
            wait_cnt_r <= wait_cnt_next_s;
        end
    end

    // Next-state logic; capture_s marks the edge that enters ACK.
    always_comb begin
        state_next_s    = state_r;
        wait_cnt_next_s = wait_cnt_r;
        capture_s       = 1'b0;
        abort_s         = 1'b0;
        case (state_r)
            ST_IDLE: begin
                wait_cnt_next_s = 4'd0;
                if (req && gate_open_s) begin
                    if (ACK_DELAY > 0) begin
                        state_next_s = ST_WAIT;
                    end else begin
                        state_next_s = ST_ACK;
                        capture_s    = 1'b1;
                    end
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (!req) begin
                    state_next_s = ST_IDLE;
                    abort_s      = 1'b1;
                end else if (wait_cnt_r == DLY_LAST) begin
                    state_next_s = ST_ACK;
                    capture_s    = 1'b1;
                end else begin
                    wait_cnt_next_s = wait_cnt_r + 4'd1;
                end
            end
            ST_ACK: begin
                if (!req) begin
                    state_next_s = ST_IDLE;
                end else begin
                    state_next_s = ST_ACK;
                end
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // Handshake outputs and byte assembly lanes; lane 3 goes straight into the FIFO.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ack_r       <= 1'b0;
            proto_err_r <= 1'b0;
            byte_idx_r  <= 2'd0;
            lane0_r     <= 8'd0;
            lane1_r     <= 8'd0;
            lane2_r     <= 8'd0;
        end else begin
            ack_r       <= (state_next_s == ST_ACK);
            proto_err_r <= abort_s;
            if (capture_s) begin
                byte_idx_r <= byte_idx_r + 2'd1;
                case (byte_idx_r)
                    2'd0:    lane0_r <= data_in;
                    2'd1:    lane1_r <= data_in;
                    2'd2:    lane2_r <= data_in;
                    default: lane2_r <= lane2_r;
                endcase
            end
        end
    end

    // FIFO pointer and occupancy bookkeeping.
    always_comb begin
        rd_next_s    = rd_ptr_r;
        count_next_s = count_r;
        if (pop_s) begin
            rd_next_s = rd_ptr_r + 1'b1;
        end else begin
            rd_next_s = rd_ptr_r;
        end
        case ({push_s, pop_s})
            2'b10:   count_next_s = count_r + 1'b1;
            2'b01:   count_next_s = count_r - 1'b1;
            default: count_next_s = count_r;
        endcase
    end

    // FIFO storage; word_data is a registered copy of the head after this edge's push/pop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_r[i] <= 32'd0;
            end
            wr_ptr_r     <= {AW{1'b0}};
            rd_ptr_r     <= {AW{1'b0}};
            count_r      <= {(AW+1){1'b0}};
            word_valid_r <= 1'b0;
            word_data_r  <= 32'd0;
        end else begin
            if (push_s) begin
                mem_r[wr_ptr_r] <= push_word_s;
                wr_ptr_r        <= wr_ptr_r + 1'b1;
            end
            rd_ptr_r     <= rd_next_s;
            count_r      <= count_next_s;
            word_valid_r <= (count_next_s != {(AW+1){1'b0}});
            if (push_s && (wr_ptr_r == rd_next_s)) begin
                word_data_r <= push_word_s;
            end else begin
                word_data_r <= mem_r[rd_next_s];
            end
        end
    end

    assign ack        = ack_r;
    assign proto_err  = proto_err_r;
    assign byte_idx   = byte_idx_r;
    assign word_valid = word_valid_r;
    assign word_data  = word_data_r;
    assign fifo_count = count_r;

endmodule

// File: tb/tb_link_slave_rx.sv
// Directed bench for link_slave_rx: one instance with no ack delay, one with ACK_DELAY=3.
module tb_link_slave_rx;

    logic        clk;
    logic        rst_n;
    logic        req,   req_d;
    logic [7:0]  data_in, data_in_d;
    logic        ack,   ack_d;
    logic        word_valid, word_valid_d;
    logic        word_ready, word_ready_d;
    logic [31:0] word_data, word_data_d;
    logic [2:0]  fifo_count, fifo_count_d;
    logic [1:0]  byte_idx, byte_idx_d;
    logic        proto_err, proto_err_d;

    int checks = 0;
    int errors = 0;

    link_slave_rx #(.ACK_DELAY(0), .FIFO_DEPTH(4)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .data_in(data_in), .ack(ack),
        .word_valid(word_valid), .word_ready(word_ready), .word_data(word_data),
        .fifo_count(fifo_count), .byte_idx(byte_idx), .proto_err(proto_err)
    );

    link_slave_rx #(.ACK_DELAY(3), .FIFO_DEPTH(4)) dut_d (
        .clk(clk), .rst_n(rst_n), .req(req_d), .data_in(data_in_d), .ack(ack_d),
        .word_valid(word_valid_d), .word_ready(word_ready_d), .word_data(word_data_d),
        .fifo_count(fifo_count_d), .byte_idx(byte_idx_d), .proto_err(proto_err_d)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    function automatic logic [31:0] stream_word(input int k);
        logic [7:0] base;
        base = 8'(8'h40 + k * 4);
        return {base + 8'd3, base + 8'd2, base + 8'd1, base};
    endfunction

    // One master handshake; noisy mode wiggles data_in outside the capture edge.
    task automatic send_byte(input bit sel_d, input logic [7:0] b, input bit noisy, output int lat);
        int n;
        @(negedge clk);
        if (sel_d) begin req_d = 1'b1; data_in_d = b; end
        else       begin req   = 1'b1; data_in   = b; end
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (((sel_d ? ack_d : ack) !== 1'b1) && lat < 40);
        if (noisy) begin
            data_in = ~b;
            repeat (2) @(negedge clk);
        end
        if (sel_d) req_d = 1'b0; else req = 1'b0;
        if (noisy) data_in = 8'h5A;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (((sel_d ? ack_d : ack) !== 1'b0) && n < 40);
        checks++;
        if (n >= 40) begin
            errors++;
            $display("FAIL ack_release: ack still %b, required 0", sel_d ? ack_d : ack);
        end
        if (noisy) begin
            data_in = 8'hC3;
            repeat (2) @(negedge clk);
        end
    endtask

    task automatic send_burst(input bit sel_d, input logic [31:0] w, input bit noisy);
        int lat;
        for (int i = 0; i < 4; i++) begin
            send_byte(sel_d, w[8*i +: 8], noisy, lat);
        end
    endtask

    task automatic pop_one();
        @(negedge clk);
        word_ready = 1'b1;
        @(negedge clk);
        word_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b1; req = 1'b0; req_d = 1'b0; data_in = 8'h00; data_in_d = 8'h00;
        word_ready = 1'b0; word_ready_d = 1'b0;
        #2 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({ack, word_valid, fifo_count, byte_idx, proto_err} !== 8'd0) begin
            errors++;
            $display("FAIL reset_ctrl: got ack=%b val=%b cnt=%0d idx=%0d perr=%b, required all 0",
                     ack, word_valid, fifo_count, byte_idx, proto_err);
        end
        checks++;
        if (word_data !== 32'd0) begin
            errors++;
            $display("FAIL reset_data: got %h, required 00000000", word_data);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_single_burst();
        int lat;
        for (int i = 0; i < 4; i++) begin
            send_byte(1'b0, 8'(8'hA0 + i), 1'b0, lat);
            checks++;
            if (lat != 1) begin
                errors++;
                $display("FAIL single_lat%0d: ack after %0d cycles, required 1", i, lat);
            end
        end
        checks++;
        if (fifo_count !== 3'd1 || word_valid !== 1'b1 || byte_idx !== 2'd0) begin
            errors++;
            $display("FAIL single_state: cnt=%0d val=%b idx=%0d, required 1 1 0",
                     fifo_count, word_valid, byte_idx);
        end
        checks++;
        if (word_data !== 32'hA3A2A1A0) begin
            errors++;
            $display("FAIL single_word: got %h, required a3a2a1a0", word_data);
        end
        pop_one();
        checks++;
        if (fifo_count !== 3'd0 || word_valid !== 1'b0) begin
            errors++;
            $display("FAIL single_pop: cnt=%0d val=%b, required 0 0", fifo_count, word_valid);
        end
    endtask

    task automatic test_backpressure();
        int lat;
        int ack_seen;
        logic [31:0] w;
        for (int k = 0; k < 4; k++) begin
            w = 32'h0 | {8'(8'h13 + 8'h10*k), 8'(8'h12 + 8'h10*k), 8'(8'h11 + 8'h10*k), 8'(8'h10 + 8'h10*k)};
            send_burst(1'b0, w, 1'b0);
        end
        checks++;
        if (fifo_count !== 3'd4) begin
            errors++;
            $display("FAIL bp_full: cnt=%0d, required 4", fifo_count);
        end
        for (int i = 0; i < 3; i++) begin
            send_byte(1'b0, 8'(8'h50 + i), 1'b0, lat);
            checks++;
            if (lat != 1) begin
                errors++;
                $display("FAIL bp_lat%0d: ack after %0d cycles, required 1", i, lat);
            end
        end
        @(negedge clk);
        req = 1'b1; data_in = 8'h53;
        ack_seen = 0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (ack === 1'b1) ack_seen++;
        end
        checks++;
        if (ack_seen != 0) begin
            errors++;
            $display("FAIL bp_stall: ack high %0d cycles, required 0", ack_seen);
        end
        word_ready = 1'b1;
        @(negedge clk);
        word_ready = 1'b0;
        checks++;
        if (fifo_count !== 3'd3 || ack !== 1'b0) begin
            errors++;
            $display("FAIL bp_pop: cnt=%0d ack=%b, required 3 0", fifo_count, ack);
        end
        @(negedge clk);
        checks++;
        if (fifo_count !== 3'd4 || ack !== 1'b1) begin
            errors++;
            $display("FAIL bp_resume: cnt=%0d ack=%b, required 4 1", fifo_count, ack);
        end
        req = 1'b0;
        @(negedge clk);
        @(negedge clk);
        word_ready = 1'b1;
        for (int k = 1; k < 5; k++) begin
            w = (k == 4) ? 32'h53525150
                         : {8'(8'h13 + 8'h10*k), 8'(8'h12 + 8'h10*k), 8'(8'h11 + 8'h10*k), 8'(8'h10 + 8'h10*k)};
            checks++;
            if (word_data !== w || word_valid !== 1'b1) begin
                errors++;
                $display("FAIL bp_drain%0d: got %h val=%b, required %h 1", k, word_data, word_valid, w);
            end
            @(negedge clk);
        end
        word_ready = 1'b0;
        checks++;
        if (fifo_count !== 3'd0) begin
            errors++;
            $display("FAIL bp_empty: cnt=%0d, required 0", fifo_count);
        end
    endtask

    task automatic test_stream();
        int got;
        int maxc;
        got = 0;
        maxc = 0;
        word_ready = 1'b1;
        fork
            begin
                for (int k = 0; k < 8; k++) send_burst(1'b0, stream_word(k), 1'b0);
            end
            begin
                for (int c = 0; c < 300 && got < 8; c++) begin
                    @(negedge clk);
                    if (int'(fifo_count) > maxc) maxc = int'(fifo_count);
                    if (word_valid === 1'b1) begin
                        checks++;
                        if (word_data !== stream_word(got)) begin
                            errors++;
                            $display("FAIL stream_word%0d: got %h, required %h", got, word_data, stream_word(got));
                        end
                        got++;
                    end
                end
            end
        join
        @(negedge clk);
        word_ready = 1'b0;
        checks++;
        if (got != 8 || maxc != 1 || fifo_count !== 3'd0) begin
            errors++;
            $display("FAIL stream_summary: words=%0d maxcnt=%0d cnt=%0d, required 8 1 0", got, maxc, fifo_count);
        end
    endtask

    task automatic test_data_change();
        send_burst(1'b0, 32'h44332211, 1'b1);
        checks++;
        if (word_data !== 32'h44332211 || fifo_count !== 3'd1) begin
            errors++;
            $display("FAIL noisy_word: got %h cnt=%0d, required 44332211 1", word_data, fifo_count);
        end
        pop_one();
    endtask

    task automatic test_ack_delay();
        int lat;
        send_byte(1'b1, 8'hD0, 1'b0, lat);
        checks++;
        if (lat != 4) begin
            errors++;
            $display("FAIL delay_lat: ack after %0d cycles, required 4", lat);
        end
        @(negedge clk);
        req_d = 1'b1; data_in_d = 8'hEE;
        @(negedge clk);
        @(negedge clk);
        req_d = 1'b0;
        @(negedge clk);
        checks++;
        if (proto_err_d !== 1'b1 || ack_d !== 1'b0) begin
            errors++;
            $display("FAIL abort_pulse: perr=%b ack=%b, required 1 0", proto_err_d, ack_d);
        end
        @(negedge clk);
        checks++;
        if (proto_err_d !== 1'b0 || byte_idx_d !== 2'd1 || fifo_count_d !== 3'd0) begin
            errors++;
            $display("FAIL abort_after: perr=%b idx=%0d cnt=%0d, required 0 1 0",
                     proto_err_d, byte_idx_d, fifo_count_d);
        end
        for (int i = 1; i < 4; i++) begin
            send_byte(1'b1, 8'(8'hD0 + i), 1'b0, lat);
            checks++;
            if (lat != 4) begin
                errors++;
                $display("FAIL delay_lat%0d: ack after %0d cycles, required 4", i, lat);
            end
        end
        checks++;
        if (word_data_d !== 32'hD3D2D1D0 || fifo_count_d !== 3'd1 || proto_err_d !== 1'b0) begin
            errors++;
            $display("FAIL delay_word: got %h cnt=%0d perr=%b, required d3d2d1d0 1 0",
                     word_data_d, fifo_count_d, proto_err_d);
        end
    endtask

    task automatic test_reset_mid();
        int lat;
        int n;
        send_burst(1'b0, 32'hB3B2B1B0, 1'b0);
        send_burst(1'b0, 32'hB7B6B5B4, 1'b0);
        send_byte(1'b0, 8'hC0, 1'b0, lat);
        send_byte(1'b0, 8'hC1, 1'b0, lat);
        @(negedge clk);
        req = 1'b1; data_in = 8'hC2;
        n = 0;
        do begin @(negedge clk); n++; end while (ack !== 1'b1 && n < 40);
        checks++;
        if (ack !== 1'b1 || fifo_count !== 3'd2 || byte_idx !== 2'd3) begin
            errors++;
            $display("FAIL mid_pre: ack=%b cnt=%0d idx=%0d, required 1 2 3", ack, fifo_count, byte_idx);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (ack !== 1'b0 || word_valid !== 1'b0 || fifo_count !== 3'd0 || byte_idx !== 2'd0) begin
            errors++;
            $display("FAIL mid_reset: ack=%b val=%b cnt=%0d idx=%0d, required 0 0 0 0",
                     ack, word_valid, fifo_count, byte_idx);
        end
        req = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        send_burst(1'b0, 32'hA3A2A1A0, 1'b0);
        checks++;
        if (word_data !== 32'hA3A2A1A0 || fifo_count !== 3'd1 || word_valid !== 1'b1) begin
            errors++;
            $display("FAIL mid_after: got %h cnt=%0d val=%b, required a3a2a1a0 1 1",
                     word_data, fifo_count, word_valid);
        end
    endtask

    initial begin
        test_reset();
        test_single_burst();
        test_backpressure();
        test_stream();
        test_data_change();
        test_ack_delay();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
